// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Merges the write-back streams of three execution units (ALU, LOAD, CSR)
//   into a single register-file write port, and keeps a scoreboard of
//   destination registers that have been issued but not yet written back.
//   Decode uses the scoreboard to detect read-after-write hazards.
//
//   - Round-robin arbitration, one grant per cycle, the output stage never
//     stalls, so any valid request is granted in the cycle it is presented.
//   - One cycle from handshake to register-file write.
//   - Writes to x0 are accepted and dropped.
//   - Scoreboard set (allocation) wins over clear (commit) on the same entry.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    [2:0]  per-requester request (0 ALU, 1 LOAD, 2 CSR)
//   req_ready    [2:0]  per-requester accept, one-hot or zero
//   req_rd       [14:0] destination per requester, 5 bits each
//   req_data     [95:0] write data per requester, 32 bits each
//   alloc_valid         issue stage marks a destination in flight
//   alloc_rd     [4:0]  destination being allocated
//   rs1, rs2     [4:0]  source registers read by decode
//   hazard1/2           source register has an in-flight write
//   wb_en               register-file write enable
//   wb_rd        [4:0]  register-file write address
//   wb_data      [31:0] register-file write data
//   pending      [31:0] scoreboard of in-flight destinations
// -----------------------------------------------------------------------------
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [14:0] req_rd,
  input  logic [95:0] req_data,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] pending
);

  // Round-robin pick: returns a one-hot grant, searching from ptr upwards
  // modulo 3. The unreachable pointer value 3 is treated like 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] ptr);
    logic [2:0] g;
    g = 3'b000;
    case (ptr)
      2'd1: begin
        if (v[1])      g = 3'b010;
        else if (v[2]) g = 3'b100;
        else if (v[0]) g = 3'b001;
        else           g = 3'b000;
      end
      2'd2: begin
        if (v[2])      g = 3'b100;
        else if (v[0]) g = 3'b001;
        else if (v[1]) g = 3'b010;
        else           g = 3'b000;
      end
      default: begin
        if (v[0])      g = 3'b001;
        else if (v[1]) g = 3'b010;
        else if (v[2]) g = 3'b100;
        else           g = 3'b000;
      end
    endcase
    return g;
  endfunction

  logic [1:0]  rr_ptr_q,  rr_ptr_d;
  logic        wb_en_q,   wb_en_d;
  logic [4:0]  wb_rd_q,   wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] pending_q, pending_d;

  logic [2:0]  grant_s;
  logic [2:0]  req_ready_s;
  logic        hs_s;
  logic [1:0]  gidx_s;
  logic [4:0]  sel_rd_s;
  logic [31:0] sel_data_s;

  // Arbitration; ready is forced low while reset is held so no handshake
  // can slip through during or at the release of reset.
  always_comb begin
    grant_s = rr_pick(req_valid, rr_ptr_q);
    if (rst_n) begin
      req_ready_s = grant_s;
    end else begin
      req_ready_s = 3'b000;
    end
  end

  // Decode the granted requester and select its destination and data.
  always_comb begin
    gidx_s     = 2'd0;
    sel_rd_s   = 5'd0;
    sel_data_s = 32'd0;
    case (req_ready_s)
      3'b001: begin
        gidx_s     = 2'd0;
        sel_rd_s   = req_rd[4:0];
        sel_data_s = req_data[31:0];
      end
      3'b010: begin
        gidx_s     = 2'd1;
        sel_rd_s   = req_rd[9:5];
        sel_data_s = req_data[63:32];
      end
      3'b100: begin
        gidx_s     = 2'd2;
        sel_rd_s   = req_rd[14:10];
        sel_data_s = req_data[95:64];
      end
      default: begin
        gidx_s     = 2'd0;
        sel_rd_s   = 5'd0;
        sel_data_s = 32'd0;
      end
    endcase
    hs_s = |(req_valid & req_ready_s);
  end

  // Next pointer and output-stage state; address and data only load on a
  // real write so they hold their last value while wb_en is low.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (hs_s) begin
      rr_ptr_d = (gidx_s == 2'd2) ? 2'd0 : (gidx_s + 2'd1);
      if (sel_rd_s != 5'd0) begin
        wb_en_d   = 1'b1;
        wb_rd_d   = sel_rd_s;
        wb_data_d = sel_data_s;
      end else begin
        wb_en_d   = 1'b0;
      end
    end else begin
      // Pull an illegal pointer back into range instead of holding it.
      rr_ptr_d = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;
    end
  end

  // Scoreboard update: clear on commit first, then set on allocation so the
  // set wins a same-cycle collision; entry 0 is hard-wired to zero.
  always_comb begin
    pending_d = pending_q;
    if (wb_en_q) begin
      pending_d[wb_rd_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (alloc_valid && (alloc_rd != 5'd0)) begin
      pending_d[alloc_rd] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; asynchronous reset discards any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= 2'd0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      pending_q <= pending_d;
    end
  end

  // Hazards read the registered scoreboard directly: no bypass, so a
  // register committing this cycle still shows as pending.
  assign hazard1   = pending_q[rs1];
  assign hazard2   = pending_q[rs2];
  assign req_ready = req_ready_s;
  assign wb_en     = wb_en_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed plus short random stimulus for rf_wb_arbiter. A small behavioural
// model predicts the grant, the scoreboard and the write-back; each predicted
// write-back is queued when the request is driven and compared after the
// clock edge on which the DUT produces it.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard1;
  logic        hazard2;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] pending;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;

  // behavioural model state
  int          m_ptr;
  logic [31:0] m_pend;
  logic        m_wben;
  logic [4:0]  m_wbrd;
  logic [31:0] m_wbdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*5 +: 5]   = rd;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic idle_inputs();
    req_valid   = 3'b000;
    alloc_valid = 1'b0;
    alloc_rd    = 5'd0;
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_pend   = 32'd0;
    m_wben   = 1'b0;
    m_wbrd   = 5'd0;
    m_wbdata = 32'd0;
    exp_q.delete();
  endtask

  // One clock cycle: check combinational outputs against the model, queue
  // the predicted write-back, cross the edge, pop and compare.
  task automatic cycle();
    int          g;
    logic [2:0]  er;
    wb_t         e;
    logic [31:0] np;
    logic [4:0]  rd;
    logic [31:0] d;
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (g < 0 && req_valid[i]) g = i;
    end
    er = 3'b000;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("hazard1", 32'(hazard1), 32'(m_pend[rs1]));
    chk("hazard2", 32'(hazard2), 32'(m_pend[rs2]));
    e.en   = 1'b0;
    e.rd   = m_wbrd;
    e.data = m_wbdata;
    if (g >= 0) begin
      rd    = req_rd[g*5 +: 5];
      d     = req_data[g*32 +: 32];
      m_ptr = (g + 1) % 3;
      if (rd != 5'd0) begin
        e.en   = 1'b1;
        e.rd   = rd;
        e.data = d;
      end
    end
    np = m_pend;
    if (m_wben) np[m_wbrd] = 1'b0;
    if (alloc_valid && alloc_rd != 5'd0) np[alloc_rd] = 1'b1;
    np[0] = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e        = exp_q.pop_front();
    m_pend   = np;
    m_wben   = e.en;
    m_wbrd   = e.rd;
    m_wbdata = e.data;
    chk("wb_en",   32'(wb_en),   32'(e.en));
    chk("wb_rd",   32'(wb_rd),   32'(e.rd));
    chk("wb_data", wb_data,      e.data);
    chk("pending", pending,      m_pend);
  endtask

  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    rst_n    = 1'b0;
    req_rd   = 15'd0;
    req_data = 96'd0;
    rs1      = 5'd7;
    rs2      = 5'd9;
    idle_inputs();
    req_valid = 3'b111;
    model_reset();

    // reset state, with requests present that must not be accepted
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_wb_en",   32'(wb_en),     32'd0);
    chk("rst_wb_rd",   32'(wb_rd),     32'd0);
    chk("rst_wb_data", wb_data,        32'd0);
    chk("rst_pending", pending,        32'd0);
    chk("rst_hazard1", 32'(hazard1),   32'd0);
    chk("rst_hazard2", 32'(hazard2),   32'd0);
    idle_inputs();
    rst_n = 1'b1;

    // single ALU request, then an idle cycle where address/data hold
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    cycle();
    chk("single_wb_data", wb_data, 32'hDEADBEEF);
    idle_inputs();
    cycle();

    // x0 drop by LOAD (pointer now 1): accepted, no write, old values held
    set_req(1, 1'b1, 5'd0, 32'h00001234);
    cycle();
    idle_inputs();
    cycle();

    // scoreboard: alloc x7 in cycle 0, ALU commits x7 granted in cycle 3
    rs1 = 5'd7;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    cycle();                                  // cycle 0
    idle_inputs();
    chk("sb_hazard1_set", 32'(hazard1), 32'd1);
    cycle();                                  // cycle 1
    cycle();                                  // cycle 2
    set_req(0, 1'b1, 5'd7, 32'h0000_0777);
    cycle();                                  // cycle 3 grant
    idle_inputs();
    cycle();                                  // cycle 4 wb_en, hazard still 1
    #1;
    chk("sb_hazard1_clr", 32'(hazard1), 32'd0);
    cycle();                                  // cycle 5

    // set/clear collision on x9, and double allocation of x12
    rs2 = 5'd9;
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    set_req(0, 1'b1, 5'd9, 32'h9999_0009);
    cycle();
    req_valid = 3'b000;
    alloc_valid = 1'b1; alloc_rd = 5'd9;      // collides with wb_rd=9
    cycle();
    chk("collide_p9", 32'(pending[9]), 32'd1);
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    cycle();
    cycle();
    idle_inputs();
    set_req(2, 1'b1, 5'd12, 32'hC5C5_000C);
    cycle();
    idle_inputs();
    cycle();

    // alloc to x0 is ignored
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    cycle();
    idle_inputs();

    // random traffic
    for (int n = 0; n < 40; n++) begin
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        req_rd[i*5 +: 5]     = 5'($urandom_range(0, 31));
        req_data[i*32 +: 32] = $urandom;
      end
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_rd    = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      cycle();
    end
    idle_inputs();

    // reset mid-stream, one cycle after a grant of x3
    rs1 = 5'd3;
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    set_req(0, 1'b1, 5'd3, 32'h3333_0003);
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb_en",   32'(wb_en),   32'd0);
    chk("mid_rst_pending", pending,      32'd0);
    chk("mid_rst_hazard1", 32'(hazard1), 32'd0);
    req_valid = 3'b111;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_inputs();
    model_reset();
    rst_n = 1'b1;
    cycle();
    cycle();

    // contention from pointer 0: ALU, LOAD, CSR, ALU
    set_req(0, 1'b1, 5'd1, 32'hA0A0_0001);
    set_req(1, 1'b1, 5'd2, 32'hB1B1_0002);
    set_req(2, 1'b1, 5'd4, 32'hC2C2_0004);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("contention_seq", 32'(req_ready), 32'(seq[k]));
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have a single clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Ports, in order:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  per-requester write-back request; bit0 ALU, bit1 LOAD, bit2 CSR
- req_ready  out  3  per-requester accept, one-hot or zero
- req_rd  in  15  destination register per requester; requester i uses bits [5i+4:5i]
- req_data  in  96  write data per requester; requester i uses bits [32i+31:32i]
- alloc_valid  in  1  issue stage marks a destination as in flight
- alloc_rd  in  5  destination being allocated
- rs1, rs2  in  5 each  source registers being read by decode
- hazard1, hazard2  out  1 each  the source register has an in-flight write
- wb_en  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  32  register-file write data
- pending  out  32  scoreboard of in-flight destinations

Function
REQ-003 SHALL grant at most one requester per cycle: req_ready[i]=1 only for the granted i, and only if req_valid[i]=1; req_ready is combinational from req_valid and rr_ptr.
REQ-004 SHALL use round-robin arbitration with a 2-bit pointer rr_ptr in {0,1,2}; priority order is rr_ptr, rr_ptr+1, rr_ptr+2, mod 3.
REQ-005 On a handshake (valid&ready) by requester g, rr_ptr SHALL become (g+1) mod 3 at the next edge; with no handshake, rr_ptr SHALL hold.
REQ-006 The output stage SHALL accept every cycle, so any valid request always produces a grant that cycle.
REQ-007 Latency SHALL be 1 cycle: a handshake in cycle N with rd!=0 gives wb_en=1, wb_rd=rd, wb_data=data in cycle N+1; with no handshake, wb_en=0 in N+1.
REQ-008 A granted request with rd=0 SHALL be accepted (ready=1, rr_ptr advances) but SHALL produce wb_en=0.
REQ-009 While wb_en=0, wb_rd and wb_data SHALL hold their previous values.
REQ-010 pending[r] SHALL be set at the edge ending a cycle with alloc_valid=1 and alloc_rd=r, r!=0.
REQ-011 pending[r] SHALL be cleared at the edge ending a cycle with wb_en=1 and wb_rd=r.
REQ-012 When a set and a clear of the same r occur in the same cycle, set SHALL win.
REQ-013 pending[0] SHALL always be 0.
REQ-014 Allocating an already-pending r SHALL leave it at 1; no count is kept, and the first commit to r clears it.
REQ-015 Hazards are combinational: hazard1=pending[rs1] and hazard2=pending[rs2]; there is no bypass, so a register committing this cycle still reports a hazard.
REQ-016 A requester SHALL hold req_rd and req_data stable while req_valid=1 and req_ready=0; the block does not check this.

Reset
REQ-017 While rst_n=0, the block SHALL force: rr_ptr=0, pending=0, wb_en=0, wb_rd=0, wb_data=0, req_ready=0, hazard1=0, hazard2=0.
REQ-018 Reset assertion mid-operation SHALL discard any in-flight output write; no write-back may occur in the cycle after release unless a handshake happens after release.
REQ-019 On the first edge after rst_n rises, the block SHALL operate normally with ALU (index 0) at highest priority.

Verification
REQ-020 Single request: after reset, ALU valid, rd=5, data=0xDEADBEEF for 1 cycle -> req_ready=001 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; rr_ptr=1.
REQ-021 Contention: all three valid continuously from rr_ptr=0 -> grants ALU, LOAD, CSR, ALU on consecutive cycles; exactly one ready bit per cycle.
REQ-022 x0 drop: LOAD valid, rd=0, data=0x1234 -> req_ready=010; next cycle wb_en=0; rr_ptr=2.
REQ-023 Scoreboard:
- alloc rd=7 in cycle 0 -> pending[7]=1; rs1=7 gives hazard1=1 from cycle 1.
- ALU writes rd=7 granted in cycle 3 -> wb_en in cycle 4 -> pending[7]=0 and hazard1=0 from cycle 5.
REQ-024 Set/clear collision: wb_en=1, wb_rd=9 and alloc_valid=1, alloc_rd=9 in the same cycle -> pending[9]=1 after the edge.
REQ-025 Reset mid-stream: assert rst_n=0 in the cycle after a grant of rd=3 -> wb_en=0 and pending=0 immediately; after release with no requests, wb_en stays 0.
